// File: rtl/usb_host_tx_scheduler.sv
// =============================================================================
// usb_host_tx_scheduler: frame timer, SOF-due tracking and TX wire arbitration
// between the SOF generator and the transaction engine.
// Revision: 1.0
// =============================================================================
`default_nettype none

module usb_host_tx_scheduler #(
  parameter int FRAME_CLKS = 48000,
  parameter int GUARD_CLKS = 600,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sofEn,
  input  logic             sofReq,
  input  logic             txnReq,
  output logic             sofDue,
  output logic             sofGnt,
  output logic             txnGnt,
  output logic [1:0]       muxSel,
  output logic [10:0]      frameNum,
  output logic [CNT_W-1:0] frameCnt,
  output logic             txnOverrun,
  output logic [7:0]       sofMissCnt
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_sof  = 2'd1;
  localparam logic [1:0] c_st_txn  = 2'd2;

  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] c_guard_lim  = CNT_W'(FRAME_CLKS - GUARD_CLKS);

  logic [1:0]       state_q, state_d;
  logic             sofDue_q, sofDue_d;
  logic             sofGnt_q, sofGnt_d;
  logic             txnGnt_q, txnGnt_d;
  logic [10:0]      frameNum_q, frameNum_d;
  logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic             txnOverrun_q, txnOverrun_d;
  logic [7:0]       sofMissCnt_q, sofMissCnt_d;

  logic w_wrap;
  logic w_guard_ok;
  logic w_sof_take;

  assign w_wrap     = sofEn && (frameCnt_q == c_frame_last);
  assign w_guard_ok = (frameCnt_q < c_guard_lim) && !sofDue_q;

  always_comb begin
    state_d      = state_q;
    sofDue_d     = sofDue_q;
    sofGnt_d     = sofGnt_q;
    txnGnt_d     = txnGnt_q;
    frameNum_d   = frameNum_q;
    frameCnt_d   = frameCnt_q;
    txnOverrun_d = 1'b0;
    sofMissCnt_d = sofMissCnt_q;
    w_sof_take   = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (sofReq && sofDue_q && sofEn) begin
          state_d    = c_st_sof;
          sofGnt_d   = 1'b1;
          sofDue_d   = 1'b0;
          w_sof_take = 1'b1;
        end else if (txnReq && w_guard_ok) begin
          state_d  = c_st_txn;
          txnGnt_d = 1'b1;
        end
      end
      c_st_sof: begin
        if (!sofReq) begin
          state_d    = c_st_idle;
          sofGnt_d   = 1'b0;
          frameNum_d = frameNum_q + 11'd1;
        end
      end
      c_st_txn: begin
        if (!txnReq) begin
          state_d  = c_st_idle;
          txnGnt_d = 1'b0;
        end
      end
      default: begin
        state_d  = c_st_idle;
        sofGnt_d = 1'b0;
        txnGnt_d = 1'b0;
      end
    endcase

    // Timer updates come after the FSM so a boundary's sofDue set overrides a grant's clear.
    if (!sofEn) begin
      frameCnt_d = '0;
      sofDue_d   = 1'b0;
    end else if (w_wrap) begin
      frameCnt_d   = '0;
      sofDue_d     = 1'b1;
      txnOverrun_d = txnGnt_q;
      if (sofDue_q && !w_sof_take && (sofMissCnt_q != 8'hFF)) begin
        sofMissCnt_d = sofMissCnt_q + 8'd1;
      end
    end else begin
      frameCnt_d = frameCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= c_st_idle;
      sofDue_q     <= 1'b0;
      sofGnt_q     <= 1'b0;
      txnGnt_q     <= 1'b0;
      frameNum_q   <= '0;
      frameCnt_q   <= '0;
      txnOverrun_q <= 1'b0;
      sofMissCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sofDue_q     <= sofDue_d;
      sofGnt_q     <= sofGnt_d;
      txnGnt_q     <= txnGnt_d;
      frameNum_q   <= frameNum_d;
      frameCnt_q   <= frameCnt_d;
      txnOverrun_q <= txnOverrun_d;
      sofMissCnt_q <= sofMissCnt_d;
    end
  end

  assign sofDue     = sofDue_q;
  assign sofGnt     = sofGnt_q;
  assign txnGnt     = txnGnt_q;
  assign muxSel     = {txnGnt_q, sofGnt_q};
  assign frameNum   = frameNum_q;
  assign frameCnt   = frameCnt_q;
  assign txnOverrun = txnOverrun_q;
  assign sofMissCnt = sofMissCnt_q;

endmodule

`default_nettype wire
